// File: rtl/cnn_top.sv
// Streaming int8 CNN: conv3x3(1->3) -> ReLU -> maxpool2x2 -> conv3x3x3(3->1) on 8x8 images.
// Weights and a ping-pong image buffer load byte-serially; one signed score per image.
module cnn_top #(
    parameter int SHIFT1 = 7,
    parameter int SHIFT2 = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic [7:0] din,
    input  logic       ram_en,
    output logic [7:0] dout,
    output logic       out_data_flag
);
    typedef enum logic [1:0] {IDLE, CONV1, CONV2} state_t;
    state_t state;

    logic signed [7:0]  weight [54];
    logic signed [7:0]  img    [2][64];
    logic signed [7:0]  pool   [27];
    logic [5:0]         wptr, pptr;
    logic               fill, job_half;
    logic [2:0]         oy, ox;
    logic               job_start;
    logic signed [7:0]  mul_a  [27];
    logic signed [7:0]  mul_b  [27];
    logic signed [15:0] prod   [27];
    logic signed [21:0] acc1   [3];
    logic signed [21:0] acc2;
    logic signed [7:0]  r1     [3];

    function automatic logic signed [7:0] sat8(input logic signed [21:0] v);
        if (v > 22'sd127)       return 8'sd127;
        else if (v < -22'sd128) return -8'sd128;
        else                    return v[7:0];
    endfunction

    assign job_start = ram_en && !mode && (pptr == 6'd63);

    // The 27 multipliers serve layer 1 during CONV1 and layer 2 otherwise.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            for (int ky = 0; ky < 3; ky++) begin
                for (int kx = 0; kx < 3; kx++) begin
                    if (state == CONV1) begin
                        mul_a[c*9+ky*3+kx] = weight[c*9+ky*3+kx];
                        mul_b[c*9+ky*3+kx] = img[job_half][{3'(oy + 3'(ky)), 3'(ox + 3'(kx))}];
                    end else begin
                        mul_a[c*9+ky*3+kx] = weight[27+c*9+ky*3+kx];
                        mul_b[c*9+ky*3+kx] = pool[c*9+ky*3+kx];
                    end
                end
            end
        end
        for (int i = 0; i < 27; i++) prod[i] = mul_a[i] * mul_b[i];
    end

    always_comb begin : sums
        logic signed [21:0] s;
        logic signed [21:0] t;
        t = '0;
        for (int c = 0; c < 3; c++) begin
            s = '0;
            for (int k = 0; k < 9; k++) s = s + 22'(prod[c*9+k]);
            acc1[c] = s;
            r1[c]   = sat8(s >>> SHIFT1);
            t       = t + s;
        end
        acc2 = t;
    end

    // Memories are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && ram_en) begin
            if (mode) weight[wptr]    <= din;
            else      img[fill][pptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            dout          <= '0;
            out_data_flag <= 1'b0;
            wptr          <= '0;
            pptr          <= '0;
            fill          <= 1'b0;
            job_half      <= 1'b0;
            oy            <= '0;
            ox            <= '0;
            for (int i = 0; i < 27; i++) pool[i] <= '0;
        end else begin
            out_data_flag <= 1'b0;
            if (ram_en) begin
                if (mode) begin
                    wptr <= (wptr == 6'd53) ? 6'd0 : wptr + 6'd1;
                end else begin
                    pptr <= pptr + 6'd1;
                    if (pptr == 6'd63) fill <= ~fill;
                end
            end
            if (job_start) begin
                // A new image always wins, even over a job in flight.
                state    <= CONV1;
                job_half <= fill;
                oy       <= '0;
                ox       <= '0;
                for (int i = 0; i < 27; i++) pool[i] <= '0;
            end else begin
                case (state)
                    CONV1: begin
                        for (int c = 0; c < 3; c++) begin
                            if (r1[c] > pool[c*9 + int'(oy[2:1])*3 + int'(ox[2:1])])
                                pool[c*9 + int'(oy[2:1])*3 + int'(ox[2:1])] <= r1[c];
                        end
                        if (ox == 3'd5) begin
                            ox <= '0;
                            if (oy == 3'd5) state <= CONV2;
                            else            oy    <= oy + 3'd1;
                        end else begin
                            ox <= ox + 3'd1;
                        end
                    end
                    CONV2: begin
                        dout          <= sat8(acc2 >>> SHIFT2);
                        out_data_flag <= 1'b1;
                        state         <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cnn_top.sv
// Directed and random checks of cnn_top against an integer reference model.
module tb_cnn_top;
    localparam int S1 = 0;
    localparam int S2 = 0;

    logic       clk = 1'b0;
    logic       rst_n, mode, ram_en;
    logic [7:0] din;
    logic [7:0] dout;
    logic       out_data_flag;

    int total = 0;
    int bad = 0;
    int flag_cnt = 0;
    logic mon_en = 1'b0;
    logic [7:0] exp_q[$];
    logic signed [7:0] tb_w [54];
    logic signed [7:0] tb_img [64];

    cnn_top #(.SHIFT1(S1), .SHIFT2(S2)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .din(din), .ram_en(ram_en),
        .dout(dout), .out_data_flag(out_data_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_i(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic logic [7:0] model();
        int pl[27];
        int acc, r, pi;
        for (int i = 0; i < 27; i++) pl[i] = 0;
        for (int oy = 0; oy < 6; oy++)
            for (int ox = 0; ox < 6; ox++)
                for (int c = 0; c < 3; c++) begin
                    acc = 0;
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++)
                            acc += int'(tb_w[c*9+ky*3+kx]) * int'(tb_img[(oy+ky)*8+ox+kx]);
                    r  = sat_i(acc >>> S1);
                    pi = c*9 + (oy/2)*3 + ox/2;
                    if (r > pl[pi]) pl[pi] = r;
                end
        acc = 0;
        for (int i = 0; i < 27; i++) acc += int'(tb_w[27+i]) * pl[i];
        return 8'(sat_i(acc >>> S2));
    endfunction

    task automatic put(input logic m, input logic [7:0] d);
        @(negedge clk);
        ram_en = 1'b1; mode = m; din = d;
        @(posedge clk); #1;
        ram_en = 1'b0;
    endtask

    task automatic load_weights();
        for (int i = 0; i < 54; i++) put(1'b1, tb_w[i]);
    endtask

    task automatic load_image(input int max_gap);
        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, max_gap)) @(posedge clk);
            put(1'b0, tb_img[i]);
        end
    endtask

    // Called right after the edge that captured byte 63.
    task automatic wait_result(input string tag, input logic [7:0] exp);
        int early = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk); #1;
            if (out_data_flag) early++;
        end
        check({tag, "_early_flag"}, early, 0);
        @(posedge clk); #1;
        check({tag, "_flag_e37"}, out_data_flag, 1);
        check({tag, "_dout"}, dout, exp);
        @(posedge clk); #1;
        check({tag, "_flag_e38"}, out_data_flag, 0);
        check({tag, "_dout_hold"}, dout, exp);
    endtask

    always @(negedge clk) begin
        if (mon_en && out_data_flag) begin
            flag_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL spurious_flag: observed=1 expected=0");
            end else begin
                check("rand_dout", dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        int cnt;
        rst_n = 1'b0; ram_en = 1'b0; mode = 1'b0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", dout, 0);
        check("reset_flag", out_data_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero weights, bright image.
        for (int i = 0; i < 54; i++) tb_w[i] = 8'sd0;
        for (int i = 0; i < 64; i++) tb_img[i] = 8'sd127;
        load_weights();
        load_image(0);
        wait_result("zero_w", 8'd0);

        // Center taps, layer-2 all ones: 27*64 saturates high.
        for (int i = 0; i < 27; i++) tb_w[i] = (i % 9 == 4) ? 8'sd1 : 8'sd0;
        for (int i = 27; i < 54; i++) tb_w[i] = 8'sd1;
        for (int i = 0; i < 64; i++) tb_img[i] = 8'sd64;
        load_weights();
        load_image(0);
        wait_result("sat_hi", 8'h7f);

        for (int i = 27; i < 54; i++) tb_w[i] = -8'sd1;
        load_weights();
        load_image(1);
        wait_result("sat_lo", 8'h80);

        // Negative pixels are removed by the ReLU-through-pool.
        for (int i = 0; i < 64; i++) tb_img[i] = -8'sd5;
        load_image(0);
        wait_result("relu", 8'h00);

        // Random back-to-back images with gaps.
        for (int i = 0; i < 54; i++) tb_w[i] = 8'($signed($urandom_range(0, 2)) - 1);
        load_weights();
        mon_en = 1'b1;
        flag_cnt = 0;
        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 64; i++) tb_img[i] = 8'($signed($urandom_range(0, 12)) - 6);
            exp_q.push_back(model());
            load_image(2);
        end
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 60) begin
            @(posedge clk);
            cnt++;
        end
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("rand_flag_count", flag_cnt, 100);
        check("rand_queue_empty", exp_q.size(), 0);

        // Partial image, reset, then a full image: only post-reset bytes count.
        for (int i = 0; i < 30; i++) put(1'b0, 8'($urandom_range(0, 255)));
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_dout", dout, 0);
        check("midreset_flag", out_data_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) tb_img[i] = 8'($signed($urandom_range(0, 12)) - 6);
        for (int i = 0; i < 64; i++) put(1'b0, tb_img[i]);
        wait_result("post_reset", model());
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (out_data_flag) cnt++;
        end
        check("post_reset_extra_flags", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
